// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives InstructionMemory, fills the IF/ID register.
// Latency: instruction at pc_q=A appears on ifid_* one clock later; redirect target after 2 clocks.
// Backpressure: stall_i freezes PC and IF/ID; optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        halt_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic [31:0] ifid_instr_o,
  output logic        misaligned_o,
  output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] redirect_count_o
`endif
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mis_q, mis_d;

  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  // Control decisions made by the FSM for this edge
  logic        redir_acc;   // redirect accepted (RUN or HALT)
  logic        fetch_fire;  // normal fetch: capture imem_instr into IF/ID
  logic        bubble;      // insert NOP bubble into IF/ID
  logic        clr_valid;   // stall+flush: only drop the valid bit

  logic [31:0] pc_plus4;
  logic [31:0] redir_pc;

  assign pc_plus4 = pc_q + 32'd4;
  assign redir_pc = {redirect_target_i[31:2], 2'b00};

  // State, PC and misalignment flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  // FSM next state and per-edge fetch decision, in priority order
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_acc  = 1'b0;
    fetch_fire = 1'b0;
    bubble     = 1'b0;
    clr_valid  = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid_i) begin
          redir_acc = 1'b1;
          pc_d      = redir_pc;
          bubble    = 1'b1;
        end else if (halt_i) begin
          bubble  = 1'b1;
          state_d = S_HALT;
        end else if (stall_i) begin
          clr_valid = flush_i;
        end else if (flush_i) begin
          pc_d   = pc_plus4;
          bubble = 1'b1;
        end else begin
          pc_d       = pc_plus4;
          fetch_fire = 1'b1;
        end
      end
      S_HALT: begin
        // halt_i has no effect here; only a redirect restarts fetch
        if (redirect_valid_i) begin
          redir_acc = 1'b1;
          pc_d      = redir_pc;
          bubble    = 1'b1;
          state_d   = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    mis_d = redir_acc && (redirect_target_i[1:0] != 2'b00);
  end

  // IF/ID next state from the FSM decision
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    if (fetch_fire) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = imem_instr;
    end else if (bubble) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (clr_valid) begin
      ifid_valid_d = 1'b0;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, redir_cnt_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      redir_cnt_q <= 32'h0;
    end else begin
      if (fetch_fire) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redir_acc)  redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign fetch_count_o    = fetch_cnt_q;
  assign redirect_count_o = redir_cnt_q;
`endif

  assign imem_addr       = pc_q;
  assign ifid_valid_o    = ifid_valid_q;
  assign ifid_pc_o       = ifid_pc_q;
  assign ifid_pc_plus4_o = ifid_pc4_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign misaligned_o    = mis_q;
  assign halted_o        = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall_i, flush_i, redirect_valid_i, halt_i;
  logic [31:0] redirect_target_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o;
  logic        misaligned_o, halted_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_o, redirect_count_o;
`endif

  logic [31:0] mem [256];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_addr         (imem_addr),
    .imem_instr        (imem_instr),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .halt_i            (halt_i),
    .ifid_valid_o      (ifid_valid_o),
    .ifid_pc_o         (ifid_pc_o),
    .ifid_pc_plus4_o   (ifid_pc_plus4_o),
    .ifid_instr_o      (ifid_instr_o),
    .misaligned_o      (misaligned_o),
    .halted_o          (halted_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_o     (fetch_count_o),
    .redirect_count_o  (redirect_count_o)
`endif
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rt;
    logic        halt;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        mis;
    logic        hlt;
  } vec_t;

  function automatic logic [31:0] memv(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic vec_t mk(input logic st, input logic fl, input logic rv, input logic [31:0] rt,
                              input logic ht, input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins,
                              input logic mis, input logic hlt);
    vec_t v;
    v.stall = st; v.flush = fl; v.rv = rv; v.rt = rt; v.halt = ht;
    v.addr = addr; v.vld = vld; v.pc = pc; v.pc4 = pc4; v.instr = ins;
    v.mis = mis; v.hlt = hlt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic vld,
                         input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins,
                         input logic mis, input logic hlt);
    chk({tag, " imem_addr"}, imem_addr, addr);
    chk({tag, " valid"}, {31'b0, ifid_valid_o}, {31'b0, vld});
    chk({tag, " ifid_pc"}, ifid_pc_o, pc);
    chk({tag, " ifid_pc4"}, ifid_pc_plus4_o, pc4);
    chk({tag, " ifid_instr"}, ifid_instr_o, ins);
    chk({tag, " misaligned"}, {31'b0, misaligned_o}, {31'b0, mis});
    chk({tag, " halted"}, {31'b0, halted_o}, {31'b0, hlt});
  endtask

  task automatic drive(input logic st, input logic fl, input logic rv, input logic [31:0] rt,
                       input logic ht);
    stall_i = st; flush_i = fl; redirect_valid_i = rv; redirect_target_i = rt; halt_i = ht;
  endtask

  vec_t vt [31];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = memv(i);

    //            st fl rv target        ht | addr          v  pc            pc4           instr       mis hlt
    vt[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        NOP,        0, 0); // BOOT
    vt[1]  = mk(0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h0,        32'h4,        memv(0),    0, 0);
    vt[2]  = mk(0, 0, 0, 32'h0,        0, 32'h8,        1, 32'h4,        32'h8,        memv(1),    0, 0);
    vt[3]  = mk(1, 0, 0, 32'h0,        0, 32'h8,        1, 32'h4,        32'h8,        memv(1),    0, 0);
    vt[4]  = mk(1, 0, 0, 32'h0,        0, 32'h8,        1, 32'h4,        32'h8,        memv(1),    0, 0);
    vt[5]  = mk(1, 0, 0, 32'h0,        0, 32'h8,        1, 32'h4,        32'h8,        memv(1),    0, 0);
    vt[6]  = mk(0, 0, 0, 32'h0,        0, 32'hC,        1, 32'h8,        32'hC,        memv(2),    0, 0);
    vt[7]  = mk(1, 0, 1, 32'h40,       0, 32'h40,       0, 32'h8,        32'hC,        NOP,        0, 0);
    vt[8]  = mk(0, 0, 0, 32'h0,        0, 32'h44,       1, 32'h40,       32'h44,       memv(16),   0, 0);
    vt[9]  = mk(0, 0, 1, 32'h22,       0, 32'h20,       0, 32'h40,       32'h44,       NOP,        1, 0);
    vt[10] = mk(0, 0, 0, 32'h0,        0, 32'h24,       1, 32'h20,       32'h24,       memv(8),    0, 0);
    vt[11] = mk(0, 0, 0, 32'h0,        0, 32'h28,       1, 32'h24,       32'h28,       memv(9),    0, 0);
    vt[12] = mk(0, 0, 1, 32'h10,       0, 32'h10,       0, 32'h24,       32'h28,       NOP,        0, 0);
    vt[13] = mk(0, 0, 0, 32'h0,        1, 32'h10,       0, 32'h24,       32'h28,       NOP,        0, 1);
    vt[14] = mk(1, 0, 0, 32'h0,        1, 32'h10,       0, 32'h24,       32'h28,       NOP,        0, 1);
    vt[15] = mk(0, 0, 0, 32'h0,        0, 32'h10,       0, 32'h24,       32'h28,       NOP,        0, 1);
    vt[16] = mk(0, 0, 1, 32'h0,        0, 32'h0,        0, 32'h24,       32'h28,       NOP,        0, 0);
    vt[17] = mk(0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h0,        32'h4,        memv(0),    0, 0);
    vt[18] = mk(0, 1, 0, 32'h0,        0, 32'h8,        0, 32'h0,        32'h4,        NOP,        0, 0);
    vt[19] = mk(0, 0, 0, 32'h0,        0, 32'hC,        1, 32'h8,        32'hC,        memv(2),    0, 0);
    vt[20] = mk(1, 1, 0, 32'h0,        0, 32'hC,        0, 32'h8,        32'hC,        memv(2),    0, 0);
    vt[21] = mk(0, 0, 0, 32'h0,        0, 32'h10,       1, 32'hC,        32'h10,       memv(3),    0, 0);
    vt[22] = mk(0, 0, 1, 32'h80,       1, 32'h80,       0, 32'hC,        32'h10,       NOP,        0, 0);
    vt[23] = mk(0, 0, 0, 32'h0,        0, 32'h84,       1, 32'h80,       32'h84,       memv(32),   0, 0);
    vt[24] = mk(0, 0, 1, 32'h3,        0, 32'h0,        0, 32'h80,       32'h84,       NOP,        1, 0);
    vt[25] = mk(0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h0,        32'h4,        memv(0),    0, 0);
    vt[26] = mk(0, 0, 1, 32'hFFFF_FFFC,0, 32'hFFFF_FFFC,0, 32'h0,        32'h4,        NOP,        0, 0);
    vt[27] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC,32'h0,        memv(255),  0, 0);
    vt[28] = mk(0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h0,        32'h4,        memv(0),    0, 0);
    vt[29] = mk(0, 0, 0, 32'h0,        0, 32'h8,        1, 32'h4,        32'h8,        memv(1),    0, 0);
    vt[30] = mk(0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h4,        32'h8,        NOP,        0, 1);

    // Reset state while rst_n is held low
    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    chk_all("reset", 32'h0, 0, 32'h0, 32'h0, NOP, 0, 0);
    rst_n = 1'b1;

    // Table: inputs applied at negedge, outputs checked at the next negedge
    for (int i = 0; i < 31; i++) begin
      drive(vt[i].stall, vt[i].flush, vt[i].rv, vt[i].rt, vt[i].halt);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vt[i].addr, vt[i].vld, vt[i].pc, vt[i].pc4,
              vt[i].instr, vt[i].mis, vt[i].hlt);
    end

    // Asynchronous reset mid-run (DUT is halted at 0x8): no clock edge before the check
    drive(0, 0, 0, 32'h0, 0);
    #1 rst_n = 1'b0;
    #1 chk_all("async_rst", 32'h0, 0, 32'h0, 32'h0, NOP, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // After release: one BOOT cycle with no fetch, then fetch resumes from RESET_PC
    @(negedge clk);
    chk_all("reboot_boot", 32'h0, 0, 32'h0, 32'h0, NOP, 0, 0);
    @(negedge clk);
    chk_all("reboot_fetch", 32'h4, 1, 32'h0, 32'h4, memv(0), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
